// File: rtl/acc_store_unit.sv
// acc_store_unit: writes an N-bit register value to memory as N/W beats.
// Ports: clk/clr, st_start/st_addr/st_data in; st_busy/st_done/st_err and mem_we/mem_addr/mem_wdata out; mem_ack in.
module acc_store_unit #(
  parameter int N   = 8,
  parameter int W   = 4,
  parameter int A   = 8,
  parameter int TMO = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         st_start,
  input  logic [A-1:0] st_addr,
  input  logic [N-1:0] st_data,
  output logic         st_busy,
  output logic         st_done,
  output logic         st_err,
  output logic         mem_we,
  output logic [A-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic         mem_ack
);

  localparam int NB = N / W;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int WW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [BW-1:0] LAST = BW'(NB - 1);
  localparam logic [WW-1:0] WMAX = WW'(TMO - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q;
  logic [NB-1:0][W-1:0]   shadow_q;
  logic [A-1:0]           base_q;
  logic [BW-1:0]          beat_q;
  logic [WW-1:0]          wait_q;
  logic                   err_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      base_q   <= '0;
      beat_q   <= '0;
      wait_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (st_start) begin
            state_q  <= XFER;
            shadow_q <= st_data;
            base_q   <= st_addr;
            beat_q   <= '0;
            wait_q   <= '0;
            err_q    <= 1'b0;
          end
        end
        XFER: begin
          // ack wins over the timeout on the same edge
          if (mem_ack) begin
            if (beat_q == LAST) begin
              state_q <= DONE;
              err_q   <= 1'b0;
            end else begin
              beat_q <= beat_q + 1'b1;
              wait_q <= '0;
            end
          end else if (wait_q == WMAX) begin
            state_q <= DONE;
            err_q   <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    st_busy   = 1'b0;
    st_done   = 1'b0;
    st_err    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      XFER: begin
        st_busy   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = base_q + A'(beat_q);
        mem_wdata = shadow_q[beat_q];
      end
      DONE: begin
        st_busy = 1'b1;
        st_done = 1'b1;
        st_err  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_acc_store_unit.sv
// tb_acc_store_unit: vector table, hand sequences and random stores
// checked against a transaction-level trace model.
module tb_acc_store_unit;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       st_start = 1'b0;
  logic [7:0] st_addr = '0;
  logic [7:0] st_data = '0;
  logic       st_busy, st_done, st_err, mem_we;
  logic [7:0] mem_addr;
  logic [3:0] mem_wdata;
  logic       mem_ack = 1'b0;

  int npass = 0;
  int ntot  = 0;

  localparam int TMO = 16;

  acc_store_unit #(.N(8), .W(4), .A(8), .TMO(TMO)) dut (
    .clk(clk), .clr(clr),
    .st_start(st_start), .st_addr(st_addr), .st_data(st_data),
    .st_busy(st_busy), .st_done(st_done), .st_err(st_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // {busy, done, err, we, addr, wdata}
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic       we;
    logic [7:0] addr;
    logic [3:0] wdata;
  } obs_t;

  typedef struct {
    obs_t exp;
    logic ack;
  } cyc_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] addr;
    int         d0;
    int         d1;
    bit         noise;
    int         lat;
    bit         err;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    ntot++;
    if (act === req) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, req);
  endtask

  function automatic obs_t cur();
    obs_t o;
    o = '{st_busy, st_done, st_err, mem_we, mem_addr, mem_wdata};
    return o;
  endfunction

  // Expected cycle trace: beat i waits d[i] cycles without ack,
  // acked on cycle d[i] unless that is >= TMO, which aborts.
  task automatic build(input logic [7:0] data, addr, input int d0, d1,
                       output cyc_t q[$]);
    int   d[2];
    bit   ab;
    cyc_t c;
    d[0] = d0; d[1] = d1; ab = 0; q = {};
    for (int i = 0; i < 2 && !ab; i++) begin
      for (int k = 0; k < TMO; k++) begin
        c.exp = '{1'b1, 1'b0, 1'b0, 1'b1, 8'((addr + i) % 256),
                  4'((data >> (4 * i)) & 8'hF)};
        c.ack = (k == d[i]);
        q.push_back(c);
        if (k == d[i]) break;
      end
      if (d[i] >= TMO) ab = 1;
    end
    c.exp = '{1'b1, 1'b1, ab, 1'b0, 8'h00, 4'h0};
    c.ack = 1'b0;
    q.push_back(c);
    c.exp = '0;
    q.push_back(c);
  endtask

  task automatic do_store(input logic [7:0] data, addr, input int d0, d1,
                          input bit noise, output int lat, output bit err);
    cyc_t q[$];
    build(data, addr, d0, d1, q);
    lat = -1; err = 0;
    st_start = 1'b1; st_data = data; st_addr = addr; mem_ack = 1'b0;
    @(negedge clk);
    foreach (q[i]) begin
      check($sformatf("trace@%0d", i), 32'(cur()), 32'(q[i].exp));
      if (st_done && lat < 0) begin lat = i + 1; err = st_err; end
      mem_ack = q[i].exp.we ? q[i].ack : 1'($urandom);
      st_start = (noise && i + 1 < q.size()) ? 1'($urandom) : 1'b0;
      if (noise) begin
        st_data = 8'($urandom);
        st_addr = 8'($urandom);
      end
      @(negedge clk);
    end
    st_start = 1'b0; mem_ack = 1'b0;
  endtask

  vec_t vt[7];

  initial begin
    int lat;
    bit err;
    vt[0] = '{8'hA5, 8'h10, 0, 0, 0, 3, 0};
    vt[1] = '{8'h3C, 8'hFF, 0, 0, 0, 3, 0};
    vt[2] = '{8'hA5, 8'h20, 3, 0, 1, 6, 0};
    vt[3] = '{8'hA5, 8'h30, 99, 0, 0, 17, 1};
    vt[4] = '{8'h77, 8'h40, 15, 0, 1, 18, 0};
    vt[5] = '{8'h5A, 8'h50, 0, 99, 0, 18, 1};
    vt[6] = '{8'hC3, 8'h80, 2, 15, 1, 20, 0};

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_outs", 32'(cur()), 32'(0));
      st_start = 1'($urandom); st_data = 8'($urandom);
      st_addr = 8'($urandom); mem_ack = 1'($urandom);
    end
    @(negedge clk);
    check("reset_outs", 32'(cur()), 32'(0));
    clr = 1'b0; st_start = 1'b0; mem_ack = 1'b0;

    foreach (vt[i]) begin
      do_store(vt[i].data, vt[i].addr, vt[i].d0, vt[i].d1, vt[i].noise,
               lat, err);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].err));
    end

    st_start = 1'b1; st_data = 8'hE1; st_addr = 8'h60;
    @(negedge clk);
    st_start = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    check("mid_beat1", 32'(cur()), 32'({4'b1001, 8'h61, 4'hE}));
    mem_ack = 1'b0; clr = 1'b1;
    @(negedge clk);
    check("mid_clr", 32'(cur()), 32'(0));
    st_start = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    check("mid_clr2", 32'(cur()), 32'(0));
    clr = 1'b0; st_start = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    check("post_clr_idle", 32'(cur()), 32'(0));
    do_store(8'h5A, 8'h40, 0, 0, 0, lat, err);
    check("post_clr_lat", 32'(lat), 32'(3));
    check("post_clr_err", 32'(err), 32'(0));

    for (int t = 0; t < 30; t++) begin
      do_store(8'($urandom), 8'($urandom), $urandom_range(0, 20),
               $urandom_range(0, 20), 1, lat, err);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/acc_store_unit.md
# acc_store_unit

Store-path sequencer for the accumulator-based processor. It takes the N-bit value held in a load/store data register and writes it to data memory as a sequence of W-bit beats over a request/acknowledge write bus, incrementing the address per beat. It sits between the accumulator/datapath registers and the memory port, and is driven by the control unit's store micro-op. The load-side registers capture data; this block is their read-out and write-back end.

## Interface
- N, 8: width of the stored register value; must be an integer multiple of W.
- W, 4: memory write-bus width; beats per store = N/W.
- A, 8: memory address width.
- TMO, 16: maximum wait cycles per beat before abort; must be ≥ 1.

- clk  in  1  clock; all state changes on its rising edge.
- clr  in  1  reset; synchronous, active-high.
- st_start  in  1  store request; sampled only in IDLE.
- st_addr  in  A  base address, captured with st_start.
- st_data  in  N  register value to store, captured with st_start.
- st_busy  out  1  high in XFER and DONE.
- st_done  out  1  one-cycle completion pulse.
- st_err  out  1  one-cycle pulse with st_done when a beat timed out.
- mem_we  out  1  write request; high throughout XFER.
- mem_addr  out  A  beat address.
- mem_wdata  out  W  beat data.
- mem_ack  in  1  memory accepted the current beat; ignored when mem_we is low.

## Operation
- States: IDLE, XFER, DONE.
- IDLE: all outputs 0. When st_start=1, capture st_data into the shadow register and st_addr into the base address, set beat=0 and wait=0, and go to XFER.
- XFER: mem_we=1, mem_addr=(base+beat) mod 2^A, mem_wdata=shadow[beat*W +: W]. Beat 0 carries the least-significant slice.
  - mem_ack=1 at an edge with beat<N/W−1: beat+1, wait=0.
  - mem_ack=1 at an edge on the last beat: go to DONE with err=0.
  - mem_ack=0 and wait<TMO−1: wait+1.
  - mem_ack=0 and wait=TMO−1: go to DONE with err=1 (abort; remaining beats are not written).
  - mem_ack has priority over the timeout on the same edge.
- DONE: st_done=1, st_err=err latched, st_busy=1, mem_we=0. Unconditionally go to IDLE next edge.
- st_start in XFER or DONE is ignored. st_data and st_addr changes after capture have no effect.
- Address arithmetic wraps modulo 2^A (base 0xFF, beat 1 → 0x00).
- clr=1 at any edge forces IDLE. Next cycle all outputs are 0, shadow/beat/wait are 0, and no done/err pulse is issued. An in-flight store is abandoned.
- The wait counter is sized to hold TMO−1. The beat counter is sized to hold N/W−1.

## Timing
- Reset values: st_busy=0, st_done=0, st_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
- st_start sampled at edge k → mem_we=1 with beat 0 from cycle k+1.
- mem_ack sampled at edge m → next beat presented from cycle m+1, with no idle cycle between beats.
- Zero-wait memory (ack always 1): beat i is valid in cycle k+1+i; st_done is high in cycle k+1+N/W. Total latency is N/W+1 cycles. The next st_start is accepted at edge k+2+N/W.
- mem_addr and mem_wdata are stable for the whole time a beat awaits ack.
- Timeout: with no ack, mem_we stays high for exactly TMO cycles of the beat, then DONE follows.

## Test plan
- Reset: hold clr=1 for 2 cycles during arbitrary stimulus → all outputs 0. Release; st_start is accepted on the next edge.
- Basic store (N=8, W=4): st_data=0xA5, st_addr=0x10, ack tied high → cycle k+1: addr 0x10, data 0x5; k+2: addr 0x11, data 0xA; k+3: st_done=1, st_err=0; k+4: IDLE.
- Wrap: st_addr=0xFF, st_data=0x3C → beats (0xFF, 0xC) then (0x00, 0x3). Done after 3 cycles.
- Wait states: ack low for 3 cycles on beat 0 → addr 0x20 and data 0x5 held 4 cycles. st_start pulsed and st_data changed to 0x00 mid-transfer are ignored, and beat 1 still sends 0xA. Done, no error.
- Timeout: ack never asserted → mem_we high for exactly 16 cycles on beat 0, then st_done=1 and st_err=1 for 1 cycle, and beat 1 is never issued. Ack arriving at wait=15 completes the beat normally.
- Reset mid-store: clr=1 while beat 1 awaits ack → next cycle mem_we=0, st_busy=0, no st_done. A new st_start=1 (st_data=0x5A, st_addr=0x40) then completes a normal 2-beat store.
